fir_mac_sequencer: RTL and testbench
====================================

// Module: fir_mac_sequencer
// PURPOSE
//  Time-multiplexed FIR controller: one multiplier-accumulator shared across all N taps.
//  Owns the circular sample buffer, the tap counter, the coefficient-ROM address sequence and the output register.
//  Sits in the microphone path between the sample source (dstream) and downstream consumers.
//  Trades the per-tap multipliers of the parallel low-pass for N+3 cycles per output sample.
// PARAMETERS
//  W       32  sample/coefficient width, signed two's complement
//  W_FRAC  16  fractional bits of samples, coefficients and output
//  N       41  tap count; coefficient ROM depth; N >= 2
// PORTS
//  clk        in   1               system clock
//  rst_n      in   1               asynchronous active-low reset
//  x          dstream.in   W       input samples (data/valid/ready)
//  y          dstream.out  W       filtered samples (data/valid/ready)
//  coef_addr  out  $clog2(N)       coefficient ROM address
//  coef_en    out  1               ROM read enable
//  coef_rdata in   W               ROM data, valid 1 cycle after coef_en
//  y_ovf      out  1               overflow flag for current y.data; meaningful when y.valid=1
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; y.valid=0; y.data=0; y_ovf=0; coef_en=0;
//   coef_addr=0; acc=0; wr_ptr=0; all N buffer entries=0; x.ready=0 while rst_n=0.
//  x.ready = (state==IDLE) && rst_n (combinational). Sequencer is the only backpressure source.
//  FSM:
//   IDLE : on x.valid&x.ready -> buf[wr_ptr]<=x.data; newest<=wr_ptr;
//          wr_ptr<=(wr_ptr==N-1)?0:wr_ptr+1; k<=0; acc<=0; -> RUN
//   RUN  : coef_en=1, coef_addr=k, sample read idx=(newest-k) mod N (wraps N-1 at 0);
//          sample registered alongside ROM read; k increments; after issuing k=N-1 -> DRAIN
//   DRAIN: final product accumulated; coef_en=0 -> OUT
//   OUT  : y.valid=1; y.data/y_ovf loaded on DRAIN->OUT edge and held stable;
//          on y.ready -> y.valid<=0 -> IDLE
//  Pipeline: product of tap k = sample_q*coef_rdata, accumulated 1 cycle after tap k is issued.
//   Tap 0 coefficient pairs with the newest sample.
//  Arithmetic: product 2W bits signed; acc 2W+$clog2(N)+1 bits signed (no internal overflow possible).
//  Output: y.data = acc[W-1+W_FRAC : W_FRAC].
//   y_ovf=1 iff acc lies outside the signed W-bit range after the >>W_FRAC shift.
//  Timing: x handshake at cycle t -> y.valid at t+N+2. Minimum input spacing N+3 cycles (y.ready=1).
//  Boundaries:
//   x.valid while not IDLE: ignored, x.ready=0, no sample captured.
//   y.ready low: remain in OUT indefinitely; y.data, y_ovf stable; x.ready=0.
//   y.ready high on OUT entry: handshake completes that cycle; IDLE next cycle.
//   wr_ptr wrap: entry N-1 followed by 0; reads wrap symmetrically.
//   First N-1 outputs after reset use zero history (buffer cleared).
//   Reset in any state: immediate return to reset values; in-flight accumulation discarded.
//   No partial y.valid pulse.
// CONFIGURATION
//  FIR_SATURATE_EN defined: on overflow, y.data clamps to 2^(W-1)-1 (positive) or -2^(W-1) (negative).
//  FIR_SATURATE_EN undefined: y.data is the raw bit slice (wraps); y_ovf still reported.
//  Latency and handshakes are identical in both builds.
// TESTING
//  Impulse: reset; x=0x00010000 then 45 zeros; ROM=h[] -> i-th y.data == h[i] for i<N; then 0.
//  Latency: x handshake at cycle 100 with y.ready=1 -> y.valid first high at cycle 143 (N=41).
//  Backpressure: y.ready=0 for 20 cycles in OUT with x.valid=1 -> y.data stable, x.ready=0;
//   next sample accepted 1 cycle after y handshake; no sample lost or duplicated.
//  Wrap: 100 consecutive ramp samples 1..100 (frac-scaled), ROM all 0x00010000 ->
//   y for sample n>=41 == sum(n-40..n).
//  Overflow: ROM all 0x7FFFFFFF, x=0x7FFFFFFF repeated -> y_ovf=1.
//   With FIR_SATURATE_EN, y.data=0x7FFFFFFF; without it, y.data == acc[47:16].
//  Reset mid-RUN: drop rst_n at tap 20 for 3 cycles -> y.valid=0 and x.ready=0 during reset;
//   a following impulse reproduces the impulse-test output exactly.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed N-tap FIR using one shared MAC, a circular sample buffer and a coefficient-ROM sequencer.
// Optional build macro FIR_SATURATE_EN clamps y_data on overflow instead of wrapping.
`default_nettype none

module fir_mac_sequencer #(
  parameter int W      = 32,
  parameter int W_FRAC = 16,
  parameter int N      = 41,
  localparam int AW    = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  x_data,
  input  logic          x_valid,
  output logic          x_ready,
  output logic [W-1:0]  y_data,
  output logic          y_valid,
  input  logic          y_ready,
  output logic          y_ovf,
  output logic [AW-1:0] coef_addr,
  output logic          coef_en,
  input  logic [W-1:0]  coef_rdata
);

  localparam int ACC_W = 2*W + AW + 1;
  localparam int HI_W  = ACC_W - W - W_FRAC;
  localparam logic [AW-1:0] LAST = AW'(N-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t                   state;
  logic [W-1:0]             sbuf [N];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic signed [W-1:0]      sample_q;
  logic                     prod_valid;
  logic signed [ACC_W-1:0]  acc;

  logic signed [2*W-1:0]    product;
  logic signed [ACC_W-1:0]  acc_next;
  logic [HI_W-1:0]          acc_hi;
  logic                     ovf_next;
  logic [W-1:0]             y_next;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
    return (p == '0) ? LAST : p - 1'b1;
  endfunction

  assign x_ready = (state == IDLE) && rst_n;

  assign product  = $signed({{W{sample_q[W-1]}}, sample_q}) *
                    $signed({{W{coef_rdata[W-1]}}, coef_rdata});
  assign acc_next = prod_valid ? acc + $signed({{(ACC_W-2*W){product[2*W-1]}}, product}) : acc;

  // Result fits iff every bit from the output sign bit upward agrees.
  assign acc_hi   = acc_next[ACC_W-1:W+W_FRAC-1];
  assign ovf_next = ~((&acc_hi) | ~(|acc_hi));

`ifdef FIR_SATURATE_EN
  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  always_comb begin
    y_next = acc_next[W-1+W_FRAC:W_FRAC];
    if (ovf_next) y_next = acc_next[ACC_W-1] ? SAT_MIN : SAT_MAX;
  end
`else
  always_comb begin
    y_next = acc_next[W-1+W_FRAC:W_FRAC];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      y_valid    <= 1'b0;
      y_data     <= '0;
      y_ovf      <= 1'b0;
      coef_en    <= 1'b0;
      coef_addr  <= '0;
      acc        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sample_q   <= '0;
      prod_valid <= 1'b0;
      for (int i = 0; i < N; i++) sbuf[i] <= '0;
    end else begin
      // A product is ready one cycle after its ROM read was issued.
      prod_valid <= coef_en;
      case (state)
        IDLE: begin
          if (x_valid && x_ready) begin
            sbuf[wr_ptr] <= x_data;
            rd_ptr       <= wr_ptr;
            wr_ptr       <= ptr_inc(wr_ptr);
            coef_addr    <= '0;
            coef_en      <= 1'b1;
            acc          <= '0;
            state        <= RUN;
          end
        end
        RUN: begin
          sample_q <= $signed(sbuf[rd_ptr]);
          rd_ptr   <= ptr_dec(rd_ptr);
          acc      <= acc_next;
          if (coef_addr == LAST) begin
            coef_en <= 1'b0;
            state   <= DRAIN;
          end else begin
            coef_addr <= coef_addr + 1'b1;
          end
        end
        DRAIN: begin
          acc       <= acc_next;
          y_data    <= y_next;
          y_ovf     <= ovf_next;
          y_valid   <= 1'b1;
          coef_addr <= '0;
          state     <= OUT;
        end
        OUT: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: impulse, latency, backpressure, wrap, overflow and mid-run reset.
`default_nettype none

module tb_fir_mac_sequencer;
  localparam int W      = 32;
  localparam int W_FRAC = 16;
  localparam int N      = 41;
  localparam int AW     = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  x_data;
  logic          x_valid;
  logic          x_ready;
  logic [W-1:0]  y_data;
  logic          y_valid;
  logic          y_ready;
  logic          y_ovf;
  logic [AW-1:0] coef_addr;
  logic          coef_en;
  logic [W-1:0]  coef_rdata = '0;

  fir_mac_sequencer #(.W(W), .W_FRAC(W_FRAC), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .y_ovf(y_ovf),
    .coef_addr(coef_addr), .coef_en(coef_en), .coef_rdata(coef_rdata)
  );

  always #5 clk = ~clk;

  logic [W-1:0] rom [N];
  int           h [N];
  always @(posedge clk) if (coef_en) coef_rdata <= rom[coef_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           checks = 0;
  int           passed = 0;
  logic [W-1:0] exp_data_q [$];
  logic         exp_ovf_q [$];
  int           last_x_hs = 0;
  int           y_hs_cyc = 0;
  bit           stall_req = 0;
  bit           chk_accept = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: actual timeout required event (cycle %0d)", name, cyc);
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [W-1:0] d, input logic [W-1:0] ed, input logic eo, input bit push);
    int n = 0;
    x_data  = d;
    x_valid = 1'b1;
    while (!x_ready && n < 300) begin @(negedge clk); n++; end
    if (!x_ready) timeout("x_accept");
    else begin
      last_x_hs = cyc;
      if (chk_accept) begin
        chk("accept_after_y_hs", cyc, y_hs_cyc + 1);
        chk_accept = 0;
      end
      if (push) begin exp_data_q.push_back(ed); exp_ovf_q.push_back(eo); end
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_data_q.size() != 0 || y_valid) && n < 300) begin @(negedge clk); n++; end
    if (exp_data_q.size() != 0 || y_valid) timeout("drain");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_impulse();
    send(32'h0001_0000, rom[0], 1'b0, 1'b1);
    for (int i = 1; i < N + 5; i++) send('0, (i < N) ? h[i] : 0, 1'b0, 1'b1);
    x_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every y handshake; optionally stalls one output.
  logic         prev_valid = 1'b0;
  logic [W-1:0] held_data;
  logic         held_ovf;
  int           bad, xbad;
  bit           stalled;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && y_valid) begin
        if (!prev_valid) chk("latency", cyc - last_x_hs, N + 2);
        stalled = 0;
        if (stall_req) begin
          stall_req = 0;
          stalled   = 1;
          held_data = y_data;
          held_ovf  = y_ovf;
          y_ready   = 1'b0;
          bad = 0; xbad = 0;
          repeat (20) begin
            @(negedge clk);
            if (y_data !== held_data || y_ovf !== held_ovf || y_valid !== 1'b1) bad++;
            if (x_ready !== 1'b0) xbad++;
          end
          chk("bp_y_stable", bad, 0);
          chk("bp_x_ready_low", xbad, 0);
          y_ready = 1'b1;
        end
        if (exp_data_q.size() == 0) begin
          checks++;
          $display("FAIL y_unexpected: actual %h required no output (cycle %0d)", y_data, cyc);
        end else begin
          chk("y_data", y_data, exp_data_q.pop_front());
          chk("y_ovf", y_ovf, exp_ovf_q.pop_front());
        end
        y_hs_cyc = cyc;
        if (stalled) chk_accept = 1;
      end
      prev_valid = y_valid && rst_n;
    end
  end

  initial begin
    int n;
    logic [W-1:0] e0, e1;
    rst_n   = 1'b0;
    x_valid = 1'b0;
    x_data  = '0;
    y_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      h[i]   = (i % 3 == 2) ? -((i + 1) * 4660) : (i + 1) * 4660;
      rom[i] = '0;
    end

    repeat (3) @(negedge clk);
    chk("rst_x_ready", x_ready, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data", y_data, 0);
    chk("rst_y_ovf", y_ovf, 0);
    chk("rst_coef_en", coef_en, 0);
    chk("rst_coef_addr", coef_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Impulse: outputs reproduce the coefficient table, then zeros.
    for (int i = 0; i < N; i++) rom[i] = h[i];
    run_impulse();
    wait_idle();

    // Ramp with unity taps: running window sums across buffer wrap, with one stalled output.
    do_reset();
    for (int i = 0; i < N; i++) rom[i] = 32'h0001_0000;
    for (int s = 1; s <= 100; s++) begin
      n = (s <= N) ? s * (s + 1) / 2 : N * s - 820;
      send(s << 16, n << 16, 1'b0, 1'b1);
      if (s == 50) stall_req = 1;
    end
    x_valid = 1'b0;
    wait_idle();

    // Overflow: (2^31-1)^2 accumulations far exceed the output range.
    do_reset();
    for (int i = 0; i < N; i++) rom[i] = 32'h7FFF_FFFF;
`ifdef FIR_SATURATE_EN
    e0 = 32'h7FFF_FFFF;
    e1 = 32'h7FFF_FFFF;
`else
    e0 = 32'hFFFF_0000;
    e1 = 32'hFFFE_0000;
`endif
    send(32'h7FFF_FFFF, e0, 1'b1, 1'b1);
    send(32'h7FFF_FFFF, e1, 1'b1, 1'b1);
    x_valid = 1'b0;
    wait_idle();

    // Reset during tap 20 discards the in-flight sample and clears history.
    do_reset();
    for (int i = 0; i < N; i++) rom[i] = h[i];
    send(32'h0003_0000, '0, 1'b0, 1'b0);
    x_valid = 1'b0;
    n = 0;
    while (!(coef_en && coef_addr == AW'(20)) && n < 100) begin @(negedge clk); n++; end
    if (!(coef_en && coef_addr == AW'(20))) timeout("tap20");
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_y_valid", y_valid, 0);
      chk("midrst_x_ready", x_ready, 0);
      chk("midrst_coef_en", coef_en, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_impulse();
    wait_idle();

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
